// File: rtl/ctr_seq_pkg.sv
// Shared types for the counter sequencer: FSM state encoding and command opcodes.
package ctr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_LOAD  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

endpackage

// File: rtl/ctr_sequencer_if.sv
// Command valid/ready handshake between the user-side controller and ctr_sequencer.
interface ctr_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/ctr_prescaler.sv
// Free-running prescaler: ticks once every limit+1 enabled cycles, cleared on demand.
module ctr_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] limit,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  // Equality compare so a live limit change takes effect at the next match.
  assign tick = en && (cnt == limit);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/ctr_sequencer.sv
// Counter controller: command FSM, prescaled count stepping, terminal detect and reload/halt.
module ctr_sequencer
  import ctr_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  ctr_sequencer_if.slave     cmd_if,
  input  logic [PRESC_W-1:0] cfg_prescale,
  input  logic [WIDTH-1:0]   cfg_limit,
  input  logic               cfg_down,
  input  logic               cfg_autoreload,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               wrap_pulse,
  output logic               done_pulse
);

  state_t state;
  logic   tick;
  logic   accept;
  logic   presc_clr;
  logic   terminal;

  // Refusing commands on tick cycles keeps count steps and commands mutually exclusive.
  assign cmd_if.cmd_ready = !reset && !((state == RUN) && tick);
  assign accept           = cmd_if.cmd_valid && cmd_if.cmd_ready;
  assign presc_clr        = (state != RUN) || accept;
  assign terminal         = cfg_down ? (count == '0) : (count == cfg_limit);

  ctr_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (state == RUN),
    .clr   (presc_clr),
    .limit (cfg_prescale),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      busy       <= 1'b0;
      wrap_pulse <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      done_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (cmd_if.cmd_op)
              OP_START: begin
                state <= RUN;
                busy  <= 1'b1;
              end
              OP_STOP:  ;
              OP_LOAD:  count <= cmd_if.cmd_data;
              OP_CLEAR: count <= '0;
            endcase
          end
        end
        RUN: begin
          if (tick) begin
            if (terminal) begin
              wrap_pulse <= 1'b1;
              if (cfg_autoreload) begin
                count <= cfg_down ? cfg_limit : '0;
              end else begin
                state      <= DONE;
                busy       <= 1'b0;
                done_pulse <= 1'b1;
              end
            end else begin
              count <= cfg_down ? count - WIDTH'(1) : count + WIDTH'(1);
            end
          end else if (accept) begin
            case (cmd_if.cmd_op)
              OP_START: ;
              OP_STOP: begin
                state <= IDLE;
                busy  <= 1'b0;
              end
              OP_LOAD:  count <= cmd_if.cmd_data;
              OP_CLEAR: begin
                state <= IDLE;
                busy  <= 1'b0;
                count <= '0;
              end
            endcase
          end
        end
        DONE: begin
          if (accept) begin
            case (cmd_if.cmd_op)
              OP_START: begin
                state <= RUN;
                busy  <= 1'b1;
                count <= cfg_down ? cfg_limit : '0;
              end
              OP_STOP:  state <= IDLE;
              OP_LOAD: begin
                state <= IDLE;
                count <= cmd_if.cmd_data;
              end
              OP_CLEAR: begin
                state <= IDLE;
                count <= '0;
              end
            endcase
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctr_sequencer.sv
// Directed-vector bench for ctr_sequencer with hand-computed expected cycle sequences.
module tb_ctr_sequencer;
  import ctr_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cfg_prescale;
  logic [3:0] cfg_limit;
  logic       cfg_down;
  logic       cfg_autoreload;
  logic [3:0] count;
  logic       busy;
  logic       wrap_pulse;
  logic       done_pulse;

  int vectors = 0;
  int errors  = 0;

  ctr_sequencer_if #(.WIDTH(4)) cmd_if ();

  ctr_sequencer #(.WIDTH(4), .PRESC_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_if         (cmd_if),
    .cfg_prescale   (cfg_prescale),
    .cfg_limit      (cfg_limit),
    .cfg_down       (cfg_down),
    .cfg_autoreload (cfg_autoreload),
    .count          (count),
    .busy           (busy),
    .wrap_pulse     (wrap_pulse),
    .done_pulse     (done_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] data);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    cyc();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst count", count, 0);
  endtask

  initial begin
    logic [3:0] exp6 [6];
    exp6 = '{4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

    reset            = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_START;
    cmd_if.cmd_data  = '0;
    cfg_prescale     = '0;
    cfg_limit        = '0;
    cfg_down         = 1'b0;
    cfg_autoreload   = 1'b0;

    // T1: reset held three cycles
    repeat (3) begin
      cyc();
      check("t1 count", count, 0);
      check("t1 busy", busy, 0);
      check("t1 ready", cmd_if.cmd_ready, 0);
      check("t1 pulses", {wrap_pulse, done_pulse}, 0);
    end
    reset = 1'b0;
    #1;
    check("t1 ready after release", cmd_if.cmd_ready, 1);

    // T2: up, limit 5, prescale 0, autoreload
    cfg_prescale = 8'd0; cfg_limit = 4'd5; cfg_down = 1'b0; cfg_autoreload = 1'b1;
    send(OP_START, 4'd0);
    for (int k = 0; k < 14; k++) begin
      check($sformatf("t2 count k=%0d", k), count, k % 6);
      check($sformatf("t2 wrap k=%0d", k), wrap_pulse, (k > 0 && k % 6 == 0));
      check($sformatf("t2 done k=%0d", k), done_pulse, 0);
      check($sformatf("t2 busy k=%0d", k), busy, 1);
      check($sformatf("t2 ready k=%0d", k), cmd_if.cmd_ready, 0);
      cyc();
    end
    do_reset();

    // T3: up, limit 2, prescale 3, halt at terminal
    cfg_prescale = 8'd3; cfg_limit = 4'd2; cfg_down = 1'b0; cfg_autoreload = 1'b0;
    send(OP_START, 4'd0);
    for (int k = 0; k < 15; k++) begin
      check($sformatf("t3 count k=%0d", k), count, (k < 4) ? 0 : (k < 8) ? 1 : 2);
      check($sformatf("t3 busy k=%0d", k), busy, (k < 12));
      check($sformatf("t3 wrap k=%0d", k), wrap_pulse, (k == 12));
      check($sformatf("t3 done k=%0d", k), done_pulse, (k == 12));
      check($sformatf("t3 ready k=%0d", k), cmd_if.cmd_ready, !(k == 3 || k == 7 || k == 11));
      cyc();
    end

    // T4: LOAD from DONE goes to IDLE, then down count with reload to 9
    cfg_prescale = 8'd0; cfg_limit = 4'd9; cfg_down = 1'b1; cfg_autoreload = 1'b1;
    send(OP_LOAD, 4'd3);
    check("t4 load count", count, 3);
    check("t4 load busy", busy, 0);
    send(OP_START, 4'd0);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t4 count k=%0d", k), count, (13 - (k % 10)) % 10);
      check($sformatf("t4 wrap k=%0d", k), wrap_pulse, (k == 4 || k == 14));
      cyc();
    end
    do_reset();

    // T5: STOP held while running with prescale 1
    cfg_prescale = 8'd1; cfg_limit = 4'd15; cfg_down = 1'b0; cfg_autoreload = 1'b1;
    send(OP_START, 4'd0);
    check("t5 k0 ready", cmd_if.cmd_ready, 1);
    check("t5 k0 count", count, 0);
    cyc();
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_STOP;
    check("t5 k1 ready", cmd_if.cmd_ready, 0);
    check("t5 k1 count", count, 0);
    check("t5 k1 busy", busy, 1);
    cyc();
    check("t5 k2 ready", cmd_if.cmd_ready, 1);
    check("t5 k2 count", count, 1);
    check("t5 k2 busy", busy, 1);
    for (int k = 3; k < 6; k++) begin
      cyc();
      check($sformatf("t5 count k=%0d", k), count, 1);
      check($sformatf("t5 busy k=%0d", k), busy, 0);
      check($sformatf("t5 ready k=%0d", k), cmd_if.cmd_ready, 1);
    end
    cmd_if.cmd_valid = 1'b0;

    // T6: reset mid-run at count 7 discards a pending LOAD
    cfg_prescale = 8'd0; cfg_limit = 4'd12;
    send(OP_CLEAR, 4'd0);
    check("t6 clear count", count, 0);
    send(OP_START, 4'd0);
    repeat (7) cyc();
    check("t6 pre-reset count", count, 7);
    reset            = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = 4'd5;
    cyc();
    check("t6 reset count", count, 0);
    check("t6 reset busy", busy, 0);
    check("t6 reset pulses", {wrap_pulse, done_pulse}, 0);
    check("t6 reset ready", cmd_if.cmd_ready, 0);
    reset            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cyc();
    check("t6 post-reset count", count, 0);
    check("t6 post-reset busy", busy, 0);
    cfg_limit = 4'd3;
    send(OP_LOAD, 4'd15);
    check("t6 load count", count, 15);
    send(OP_START, 4'd0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t6 count k=%0d", k), count, exp6[k]);
      check($sformatf("t6 wrap k=%0d", k), wrap_pulse, (k == 5));
      cyc();
    end
    do_reset();

    // T7: limit 0 halts on first tick; DONE START down reloads; RUN LOAD/START/CLEAR
    cfg_prescale = 8'd0; cfg_limit = 4'd0; cfg_down = 1'b0; cfg_autoreload = 1'b0;
    send(OP_START, 4'd0);
    check("t7 k0 busy", busy, 1);
    check("t7 k0 ready", cmd_if.cmd_ready, 0);
    cyc();
    check("t7 k1 count", count, 0);
    check("t7 k1 busy", busy, 0);
    check("t7 k1 wrap", wrap_pulse, 1);
    check("t7 k1 done", done_pulse, 1);
    cyc();
    check("t7 k2 pulses", {wrap_pulse, done_pulse}, 0);
    cfg_prescale = 8'd3; cfg_limit = 4'd6; cfg_down = 1'b1;
    send(OP_START, 4'd0);
    check("t7 restart count", count, 6);
    check("t7 restart busy", busy, 1);
    send(OP_LOAD, 4'd2);
    check("t7 run load count", count, 2);
    check("t7 run load busy", busy, 1);
    send(OP_START, 4'd0);
    check("t7 run start count", count, 2);
    check("t7 run start busy", busy, 1);
    send(OP_CLEAR, 4'd0);
    check("t7 clear count", count, 0);
    check("t7 clear busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
